// File: rtl/vga_pkg.sv
// Shared VGA stream widths, start-sprite geometry and the blink state type.
package vga_pkg;
  localparam int HCNT_W       = 11;
  localparam int RGB_W        = 12;
  localparam int START_W      = 400;
  localparam int START_H      = 48;
  localparam int START_ADDR_W = 15;

  localparam logic [RGB_W-1:0] KEY_COLOR = 12'hF0F;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    SHOW = 2'd1,
    HIDE = 2'd2
  } blink_state_t;
endpackage

// File: rtl/vga_delay.sv
// Fixed-depth shift register, cleared by reset, used to keep side signals
// aligned with the registered ROM read.
module vga_delay #(
  parameter int DEPTH = 1,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  logic [DEPTH-1:0][W-1:0] pipe_q, pipe_d;

  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = din;
    for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pipe_q <= '0;
    else        pipe_q <= pipe_d;
  end

  assign dout = pipe_q[DEPTH-1];
endmodule

// File: rtl/start_draw.sv
// Blinking "start" sprite overlay; drives the external start ROM and keeps the
// VGA stream aligned across the ROM's one-clock read latency.
//   state | meaning
//   OFF   | sprite disabled, frame counter held at 0
//   SHOW  | sprite drawn this frame
//   HIDE  | sprite suppressed this frame
module start_draw #(
  parameter int                         WIDTH        = vga_pkg::START_W,
  parameter int                         HEIGHT       = vga_pkg::START_H,
  parameter int                         BLINK_FRAMES = 30,
  parameter logic [vga_pkg::RGB_W-1:0]  KEY_COLOR    = vga_pkg::KEY_COLOR
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             enable,
  input  logic [vga_pkg::HCNT_W-1:0]       xpos,
  input  logic [vga_pkg::HCNT_W-1:0]       ypos,
  input  logic [vga_pkg::HCNT_W-1:0]       hcount,
  input  logic [vga_pkg::HCNT_W-1:0]       vcount,
  input  logic                             hsync,
  input  logic                             vsync,
  input  logic                             hblnk,
  input  logic                             vblnk,
  input  logic [vga_pkg::RGB_W-1:0]        rgb_in,
  output logic [vga_pkg::START_ADDR_W-1:0] rom_addr,
  input  logic [vga_pkg::RGB_W-1:0]        rom_pixel,
  output logic [vga_pkg::HCNT_W-1:0]       hcount_out,
  output logic [vga_pkg::HCNT_W-1:0]       vcount_out,
  output logic                             hsync_out,
  output logic                             vsync_out,
  output logic                             hblnk_out,
  output logic                             vblnk_out,
  output logic [vga_pkg::RGB_W-1:0]        rgb_out
);
  import vga_pkg::*;

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int BUS_W = 2 * HCNT_W + 4;
  localparam logic [HCNT_W:0]  W_M1    = (HCNT_W + 1)'(WIDTH - 1);
  localparam logic [HCNT_W:0]  H_M1    = (HCNT_W + 1)'(HEIGHT - 1);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(BLINK_FRAMES - 1);

  blink_state_t            state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    vsync_q;
  logic [HCNT_W-1:0]       x_q, x_d, y_q, y_d;
  logic [START_ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [RGB_W-1:0]        rgb_q, rgb_d;
  logic                    tick, in_box, box_d;
  logic [HCNT_W-1:0]       dx, dy;
  logic [HCNT_W:0]         hc_ext, vc_ext, x_ext, y_ext;
  logic [RGB_W-1:0]        rgb_dly;
  logic [BUS_W-1:0]        bus_out;

  assign tick = vsync & ~vsync_q;

  // Disable has priority over a tick so OFF wins when both arrive together.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = tick ? xpos : x_q;
    y_d     = tick ? ypos : y_q;
    if (!enable) begin
      state_d = OFF;
      cnt_d   = '0;
    end else if (tick) begin
      case (state_q)
        OFF: begin
          state_d = SHOW;
          cnt_d   = '0;
        end
        default: begin
          if (cnt_q == CNT_TOP) begin
            state_d = (state_q == SHOW) ? HIDE : SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

  // One extra bit keeps x+WIDTH-1 from wrapping near the right screen edge.
  always_comb begin
    hc_ext     = {1'b0, hcount};
    vc_ext     = {1'b0, vcount};
    x_ext      = {1'b0, x_q};
    y_ext      = {1'b0, y_q};
    in_box     = (hc_ext >= x_ext) && (hc_ext <= x_ext + W_M1) &&
                 (vc_ext >= y_ext) && (vc_ext <= y_ext + H_M1);
    dx         = hcount - x_q;
    dy         = vcount - y_q;
    rom_addr_d = in_box ? START_ADDR_W'(32'(dy) * 32'(WIDTH) + 32'(dx)) : '0;
  end

  always_comb begin
    rgb_d = rgb_dly;
    if (box_d && state_q == SHOW && rom_pixel != KEY_COLOR) rgb_d = rom_pixel;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= OFF;
      cnt_q      <= '0;
      vsync_q    <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      rom_addr_q <= '0;
      rgb_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      vsync_q    <= vsync;
      x_q        <= x_d;
      y_q        <= y_d;
      rom_addr_q <= rom_addr_d;
      rgb_q      <= rgb_d;
    end
  end

  vga_delay #(.DEPTH(3), .W(BUS_W)) u_stream_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .din  ({hcount, vcount, hsync, vsync, hblnk, vblnk}),
    .dout (bus_out)
  );

  vga_delay #(.DEPTH(2), .W(RGB_W)) u_rgb_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (rgb_in),
    .dout (rgb_dly)
  );

  // Blanking is folded into the hit flag so only one bit needs delaying.
  vga_delay #(.DEPTH(2), .W(1)) u_box_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (in_box & ~hblnk & ~vblnk),
    .dout (box_d)
  );

  assign {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} = bus_out;
  assign rom_addr = rom_addr_q;
  assign rgb_out  = rgb_q;
endmodule

// File: tb/tb_start_draw.sv
// Bench for start_draw: table vectors, directed multi-cycle sequences and a
// randomized stream checked against a frame-level behavioural model.
module tb_start_draw;
  import vga_pkg::*;

  localparam int BF = 2;
  localparam int NV = 8000;

  logic        clk = 1'b0;
  logic        rst_n, enable;
  logic [10:0] xpos, ypos, hcount, vcount;
  logic        hsync, vsync, hblnk, vblnk;
  logic [11:0] rgb_in;
  logic [14:0] rom_addr;
  logic [11:0] rom_pixel = 12'h000;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;
  logic        rom_key = 1'b0;

  start_draw #(.WIDTH(400), .HEIGHT(48), .BLINK_FRAMES(BF), .KEY_COLOR(12'hF0F)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .xpos(xpos), .ypos(ypos),
    .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync),
    .hblnk(hblnk), .vblnk(vblnk), .rgb_in(rgb_in), .rom_addr(rom_addr),
    .rom_pixel(rom_pixel), .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out),
    .vblnk_out(vblnk_out), .rgb_out(rgb_out)
  );

  always #5 clk = ~clk;

  // Registered ROM: pixel = low 12 address bits, or all-key when rom_key is set.
  always @(posedge clk) rom_pixel <= rom_key ? 12'hF0F : rom_addr[11:0];

  typedef struct {
    logic        rst_n, enable;
    logic [10:0] xpos, ypos, hc, vc;
    logic        hs, vs, hb, vb;
    logic [11:0] rgb;
    logic        key;
  } vec_t;

  typedef struct {
    logic [10:0] hc, vc;
    logic        hb;
    logic [11:0] rgb;
    logic [14:0] exp_addr;
    logic [11:0] exp_rgb;
  } tv_t;

  logic        v_rst[NV], v_inbox[NV], v_hs[NV], v_vs[NV], v_hb[NV], v_vb[NV];
  logic        v_key[NV], v_vis[NV];
  logic [14:0] v_addr[NV];
  logic [11:0] v_rgb[NV];
  logic [10:0] v_hc[NV], v_vc[NV];

  int total = 0;
  int bad   = 0;
  int nvec  = 0;
  bit m_on = 0, m_prev_vs = 0;
  int m_ticks = 0, m_px = 0, m_py = 0;
  vec_t base;
  tv_t  tbl[8];
  bit   exp_vis[6] = '{1, 1, 0, 0, 1, 1};

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic check_model(input int n);
    int m;
    logic [11:0] pix, e_rgb;
    logic [37:0] e_bus;
    logic draw;
    chk("rom_addr_model", 64'(rom_addr), 64'(v_addr[n]));
    if (n >= 2) begin
      m = n - 2;
      if (v_rst[n] || v_rst[n-1] || v_rst[m]) begin
        e_bus = '0;
      end else begin
        pix   = v_key[m+1] ? 12'hF0F : v_addr[m][11:0];
        draw  = v_inbox[m] && v_vis[m+1] && !v_hb[m] && !v_vb[m] && (pix != 12'hF0F);
        e_rgb = draw ? pix : v_rgb[m];
        e_bus = {v_hc[m], v_vc[m], v_hs[m], v_vs[m], v_hb[m], v_vb[m], e_rgb};
      end
      chk("stream_model",
          64'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out}),
          64'(e_bus));
    end
  endtask

  task automatic drive(input vec_t v);
    int n, a;
    bit inb, tick;
    if (nvec >= NV) begin
      $display("FAIL vector_budget got=%0d exp<%0d", nvec, NV);
      $fatal(1, "vector budget exhausted");
    end
    n = nvec;
    rst_n = v.rst_n; enable = v.enable; xpos = v.xpos; ypos = v.ypos;
    hcount = v.hc; vcount = v.vc; hsync = v.hs; vsync = v.vs;
    hblnk = v.hb; vblnk = v.vb; rgb_in = v.rgb; rom_key = v.key;
    inb = (int'(v.hc) >= m_px) && (int'(v.hc) <= m_px + 399) &&
          (int'(v.vc) >= m_py) && (int'(v.vc) <= m_py + 47);
    a = inb ? ((int'(v.vc) - m_py) * 400 + (int'(v.hc) - m_px)) % 32768 : 0;
    v_rst[n] = !v.rst_n;   v_inbox[n] = v.rst_n && inb;
    v_addr[n] = v.rst_n ? 15'(a) : 15'd0;
    v_rgb[n] = v.rgb; v_hc[n] = v.hc; v_vc[n] = v.vc; v_hs[n] = v.hs;
    v_vs[n] = v.vs; v_hb[n] = v.hb; v_vb[n] = v.vb; v_key[n] = v.key;
    if (!v.rst_n) begin
      m_on = 0; m_ticks = 0; m_px = 0; m_py = 0; m_prev_vs = 0;
    end else begin
      tick = v.vs && !m_prev_vs;
      m_prev_vs = v.vs;
      if (tick) begin m_px = int'(v.xpos); m_py = int'(v.ypos); end
      if (!v.enable) begin
        m_on = 0; m_ticks = 0;
      end else if (tick) begin
        if (!m_on) begin m_on = 1; m_ticks = 0; end
        else m_ticks++;
      end
    end
    v_vis[n] = m_on && ((m_ticks / BF) % 2 == 0);
    @(posedge clk);
    @(negedge clk);
    check_model(n);
    nvec++;
  endtask

  task automatic idle(input int cnt);
    vec_t v;
    for (int i = 0; i < cnt; i++) begin
      v = base; v.hb = 1'b1; v.vb = 1'b1;
      drive(v);
    end
  endtask

  task automatic tick_frame();
    base.vs = 1'b1; idle(2);
    base.vs = 1'b0; idle(2);
  endtask

  task automatic probe(input string name, input logic [10:0] hc, input logic [10:0] vc,
                       input logic [11:0] rgb, input logic [11:0] exp_rgb);
    vec_t v;
    v = base; v.hc = hc; v.vc = vc; v.rgb = rgb; v.hb = 1'b0; v.vb = 1'b0;
    drive(v);
    idle(2);
    chk(name, 64'(rgb_out), 64'(exp_rgb));
  endtask

  task automatic do_reset();
    base.rst_n = 1'b0; idle(2);
    base.rst_n = 1'b1; idle(1);
  endtask

  initial begin
    vec_t v;
    tbl[0] = '{11'd200, 11'd100, 1'b0, 12'h555, 15'd0,     12'h000};
    tbl[1] = '{11'd599, 11'd147, 1'b0, 12'h555, 15'd19199, 12'hAFF};
    tbl[2] = '{11'd600, 11'd147, 1'b0, 12'h321, 15'd0,     12'h321};
    tbl[3] = '{11'd199, 11'd100, 1'b0, 12'h321, 15'd0,     12'h321};
    tbl[4] = '{11'd200, 11'd148, 1'b0, 12'h321, 15'd0,     12'h321};
    tbl[5] = '{11'd300, 11'd120, 1'b0, 12'h456, 15'd8100,  12'hFA4};
    tbl[6] = '{11'd210, 11'd100, 1'b1, 12'h789, 15'd10,    12'h789};
    tbl[7] = '{11'd455, 11'd109, 1'b0, 12'h0AB, 15'd3855,  12'h0AB};

    base.rst_n = 1'b0; base.enable = 1'b0; base.xpos = 11'd200; base.ypos = 11'd100;
    base.hc = 11'd123; base.vc = 11'd45; base.hs = 1'b1; base.vs = 1'b0;
    base.hb = 1'b0; base.vb = 1'b0; base.rgb = 12'hABC; base.key = 1'b0;

    // Reset with a static stream, then release.
    for (int i = 0; i < 4; i++) drive(base);
    chk("reset_zero",
        64'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out, rom_addr}),
        64'(0));
    base.rst_n = 1'b1;
    for (int i = 0; i < 3; i++) drive(base);
    chk("release_stream", 64'({hcount_out, vcount_out, hsync_out, rgb_out}),
        64'({11'd123, 11'd45, 1'b1, 12'hABC}));

    // Corner addresses and draw decisions at position (200,100).
    base.enable = 1'b1;
    tick_frame();
    for (int i = 0; i < 8; i++) begin
      v = base; v.hc = tbl[i].hc; v.vc = tbl[i].vc; v.hb = tbl[i].hb; v.vb = 1'b0;
      v.rgb = tbl[i].rgb;
      drive(v);
      chk($sformatf("tbl_addr_%0d", i), 64'(rom_addr), 64'(tbl[i].exp_addr));
      idle(2);
      chk($sformatf("tbl_rgb_%0d", i), 64'(rgb_out), 64'(tbl[i].exp_rgb));
    end

    // Whole box transparent.
    base.key = 1'b1; idle(1);
    probe("key_tl", 11'd200, 11'd100, 12'h123, 12'h123);
    probe("key_mid", 11'd400, 11'd125, 12'h123, 12'h123);
    probe("key_br", 11'd599, 11'd147, 12'h123, 12'h123);
    base.key = 1'b0; idle(1);

    // Blink schedule with BLINK_FRAMES=2.
    do_reset();
    for (int t = 0; t < 6; t++) begin
      tick_frame();
      probe($sformatf("blink_t%0d", t), 11'd205, 11'd105, 12'h0AB,
            exp_vis[t] ? 12'h7D5 : 12'h0AB);
    end

    // Position change mid-frame waits for the next tick.
    do_reset();
    tick_frame();
    probe("pos_old_a", 11'd210, 11'd105, 12'h0AB, 12'h7DA);
    base.xpos = 11'd300;
    probe("pos_old_b", 11'd210, 11'd105, 12'h0AB, 12'h7DA);
    tick_frame();
    probe("pos_new_out", 11'd210, 11'd105, 12'h0AB, 12'h0AB);
    probe("pos_new_in", 11'd310, 11'd105, 12'h0AB, 12'h7DA);

    // Enable dropped mid-frame.
    probe("en_before", 11'd350, 11'd110, 12'h0CD, 12'hFD2);
    base.enable = 1'b0;
    probe("en_drop", 11'd350, 11'd110, 12'h0CD, 12'h0CD);
    chk("en_state_off", 64'(dut.state_q), 64'(OFF));
    chk("en_cnt_zero", 64'(dut.cnt_q), 64'(0));

    // Tick and enable fall in the same cycle.
    base.enable = 1'b1; tick_frame();
    probe("tie_show", 11'd350, 11'd110, 12'h0CD, 12'hFD2);
    base.enable = 1'b0; base.vs = 1'b1; idle(1);
    base.vs = 1'b0; idle(1);
    probe("tie_off", 11'd350, 11'd110, 12'h0CD, 12'h0CD);
    chk("tie_state_off", 64'(dut.state_q), 64'(OFF));

    // Randomized stream against the model.
    base.enable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) base.enable = !base.enable;
      if ($urandom_range(0, 39) == 0) base.vs = !base.vs;
      if ($urandom_range(0, 49) == 0) base.xpos = 11'($urandom_range(0, 2047));
      if ($urandom_range(0, 49) == 0) base.ypos = 11'($urandom_range(0, 700));
      v = base;
      v.rst_n = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 1) == 0) begin
        v.hc = 11'(m_px + int'($urandom_range(0, 410)) - 5);
        v.vc = 11'(m_py + int'($urandom_range(0, 56)) - 4);
      end else begin
        v.hc = 11'($urandom_range(0, 2047));
        v.vc = 11'($urandom_range(0, 2047));
      end
      v.hs  = 1'($urandom_range(0, 1));
      v.hb  = ($urandom_range(0, 7) == 0);
      v.vb  = ($urandom_range(0, 7) == 0);
      v.rgb = 12'($urandom_range(0, 4095));
      v.key = ($urandom_range(0, 9) == 0);
      drive(v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
